// File: rtl/fma_pkg.sv
// Shared helpers for the dot-product engine: width arithmetic and the
// saturation bounds used by the accumulator clamp.
package fma_pkg;

    // Widest accumulator the saturation helpers can describe.
    localparam int MAX_W = 64;

    // Ceiling log2, with clog2(1) = 0 so a single-lane tree adds no growth bits.
    function automatic int clog2(input int value);
        int r;
        int p;
        r = 0;
        p = 1;
        for (int i = 0; i < 31; i++) begin
            if (p < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
            p = p * 2;
        end
        return r;
    endfunction

    // Full-precision product width for one lane.
    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

    // Adder tree output width: enough growth bits that the sum never wraps.
    function automatic int tree_width(input int in_w, input int lanes);
        return in_w + clog2(lanes);
    endfunction

    // Largest representable accumulator value, right-aligned in MAX_W bits.
    function automatic logic [MAX_W-1:0] sat_max(input int acc_w, input bit is_signed);
        logic [MAX_W-1:0] r;
        if (is_signed) begin
            r = (64'd1 << (acc_w - 1)) - 64'd1;
        end else begin
            r = (64'd1 << acc_w) - 64'd1;
        end
        return r;
    endfunction

    // Smallest representable accumulator value, right-aligned in MAX_W bits.
    function automatic logic [MAX_W-1:0] sat_min(input int acc_w, input bit is_signed);
        logic [MAX_W-1:0] r;
        if (is_signed) begin
            r = 64'd1 << (acc_w - 1);
        end else begin
            r = 64'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fma_adder_tree.sv
// Combinational pairwise reduction of LANES products into one sum that is
// wide enough to never overflow.
module fma_adder_tree
    import fma_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int IN_W   = 16,
    parameter int SIGNED = 0
) (
    input  logic [LANES*IN_W-1:0]          in_data,
    output logic [IN_W+clog2(LANES)-1:0]   sum
);

    localparam int OUT_W  = tree_width(IN_W, LANES);
    localparam int LEVELS = clog2(LANES);

    // Extend every lane to the output width, then fold neighbours level by level.
    always_comb begin
        logic [OUT_W-1:0] node_s [LANES];
        for (int i = 0; i < LANES; i++) begin
            if (SIGNED != 32'sd0) begin
                node_s[i] = OUT_W'($signed(in_data[i*IN_W +: IN_W]));
            end else begin
                node_s[i] = OUT_W'(in_data[i*IN_W +: IN_W]);
            end
        end
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = 0; i < LANES; i++) begin
                if (((i % (32'sd2 << lvl)) == 32'sd0) && ((i + (32'sd1 << lvl)) < LANES)) begin
                    node_s[i] = node_s[i] + node_s[i + (32'sd1 << lvl)];
                end else begin
                    node_s[i] = node_s[i];
                end
            end
        end
        sum = node_s[0];
    end

endmodule

// File: rtl/fma_dot_engine.sv
// Pipelined dot-product / multiply-accumulate engine. Three register stages:
// lane products, adder-tree sum, accumulator with result register. A stalled
// result freezes the whole pipeline so no beat is lost or duplicated.
module fma_dot_engine
    import fma_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_result,
    output logic                    out_overflow
);

    localparam int PROD_W = prod_width(DATA_W);
    localparam int SUM_W  = tree_width(PROD_W, LANES);
    // One guard bit above the wider of accumulator and sum, so the raw add is exact.
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 32'sd0));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 32'sd0));

    logic                    en_s;
    logic [LANES*PROD_W-1:0] prod_s;
    logic [LANES*PROD_W-1:0] s1_prod_r;
    logic                    s1_valid_r;
    logic                    s1_last_r;
    logic [SUM_W-1:0]        sum_s;
    logic [SUM_W-1:0]        s2_sum_r;
    logic                    s2_valid_r;
    logic                    s2_last_r;
    logic [EXT_W-1:0]        acc_ext_s;
    logic [EXT_W-1:0]        sum_ext_s;
    logic [EXT_W-1:0]        raw_s;
    logic                    ovf_s;
    logic [ACC_W-1:0]        acc_next_s;
    logic [ACC_W-1:0]        acc_r;
    logic                    ovf_sticky_r;
    logic                    out_valid_r;
    logic [ACC_W-1:0]        out_result_r;
    logic                    out_overflow_r;

    // Everything advances unless a result is waiting on a stalled consumer.
    assign en_s         = ~(out_valid_r & ~out_ready);
    assign in_ready     = en_s;
    assign out_valid    = out_valid_r;
    assign out_result   = out_result_r;
    assign out_overflow = out_overflow_r;

    // Per-lane full-precision multiply, signed or unsigned.
    always_comb begin
        prod_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (SIGNED != 32'sd0) begin
                prod_s[i*PROD_W +: PROD_W] = PROD_W'($signed(in_a[i*DATA_W +: DATA_W]))
                                           * PROD_W'($signed(in_b[i*DATA_W +: DATA_W]));
            end else begin
                prod_s[i*PROD_W +: PROD_W] = PROD_W'(in_a[i*DATA_W +: DATA_W])
                                           * PROD_W'(in_b[i*DATA_W +: DATA_W]);
            end
        end
    end

    fma_adder_tree #(
        .LANES  (LANES),
        .IN_W   (PROD_W),
        .SIGNED (SIGNED)
    ) u_adder_tree (
        .in_data (s1_prod_r),
        .sum     (sum_s)
    );

    // Accumulate at guard-bit width, flag range escape, then clamp or wrap.
    always_comb begin
        acc_ext_s  = '0;
        sum_ext_s  = '0;
        raw_s      = '0;
        ovf_s      = 1'b0;
        acc_next_s = '0;
        if (SIGNED != 32'sd0) begin
            acc_ext_s = EXT_W'($signed(acc_r));
            sum_ext_s = EXT_W'($signed(s2_sum_r));
        end else begin
            acc_ext_s = EXT_W'(acc_r);
            sum_ext_s = EXT_W'(s2_sum_r);
        end
        raw_s = acc_ext_s + sum_ext_s;
        if (SIGNED != 32'sd0) begin
            ovf_s = ~((&raw_s[EXT_W-1:ACC_W-1]) | ~(|raw_s[EXT_W-1:ACC_W-1]));
        end else begin
            ovf_s = |raw_s[EXT_W-1:ACC_W];
        end
        if (ovf_s && (SATURATE != 32'sd0)) begin
            if ((SIGNED != 32'sd0) && raw_s[EXT_W-1]) begin
                acc_next_s = SAT_MIN;
            end else begin
                acc_next_s = SAT_MAX;
            end
        end else begin
            acc_next_s = raw_s[ACC_W-1:0];
        end
    end

    // Product and tree-sum stages, frozen together while the result is stalled.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_prod_r  <= '0;
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s2_sum_r   <= '0;
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
        end else if (en_s) begin
            s1_prod_r  <= prod_s;
            s1_valid_r <= in_valid;
            s1_last_r  <= in_valid & in_last;
            s2_sum_r   <= sum_s;
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
        end
    end

    // Accumulator and result register; a closing beat publishes and clears in one edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc_r          <= '0;
            ovf_sticky_r   <= 1'b0;
            out_valid_r    <= 1'b0;
            out_result_r   <= '0;
            out_overflow_r <= 1'b0;
        end else if (en_s) begin
            // With en high any held result is either absent or being taken now.
            out_valid_r <= 1'b0;
            if (s2_valid_r) begin
                if (s2_last_r) begin
                    out_result_r   <= acc_next_s;
                    out_overflow_r <= ovf_sticky_r | ovf_s;
                    out_valid_r    <= 1'b1;
                    acc_r          <= '0;
                    ovf_sticky_r   <= 1'b0;
                end else begin
                    acc_r          <= acc_next_s;
                    ovf_sticky_r   <= ovf_sticky_r | ovf_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_fma_dot_engine.sv
// Scoreboard bench for fma_dot_engine: four parameterisations share one
// operand bus; each beat's expected result is queued at issue time and a
// separate monitor pops and compares on every output handshake.
module tb_fma_dot_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_last;
    logic        out_ready;
    logic [3:0]  vin;
    logic [3:0]  rdy;
    logic [3:0]  ov;
    logic [3:0]  ovf;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic        ov0, ov1, ov2, ov3;
    logic        ovf0, ovf1, ovf2, ovf3;
    logic [31:0] res0, res1;
    logic [15:0] res2, res3;
    logic [31:0] res [4];

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    assign rdy    = {rdy3, rdy2, rdy1, rdy0};
    assign ov     = {ov3, ov2, ov1, ov0};
    assign ovf    = {ovf3, ovf2, ovf1, ovf0};
    assign res[0] = res0;
    assign res[1] = res1;
    assign res[2] = {16'd0, res2};
    assign res[3] = {16'd0, res3};

    fma_dot_engine u_dut0 (
        .clk_clk(clk), .reset_reset_n(rst_n), .in_valid(vin[0]), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov0),
        .out_ready(out_ready), .out_result(res0), .out_overflow(ovf0));

    fma_dot_engine #(.SIGNED(1)) u_dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .in_valid(vin[1]), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov1),
        .out_ready(out_ready), .out_result(res1), .out_overflow(ovf1));

    fma_dot_engine #(.ACC_W(16), .SATURATE(1)) u_dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .in_valid(vin[2]), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov2),
        .out_ready(out_ready), .out_result(res2), .out_overflow(ovf2));

    fma_dot_engine #(.ACC_W(16), .SATURATE(0)) u_dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n), .in_valid(vin[3]), .in_ready(rdy3),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov3),
        .out_ready(out_ready), .out_result(res3), .out_overflow(ovf3));

    // Same byte on all eight lanes.
    function automatic logic [63:0] rep(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_result(input int d, input logic [31:0] r, input logic o);
        exp_t e;
        e.id  = 2'(d);
        e.res = r;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Offer one beat to DUT d and return just after the edge that accepts it.
    task automatic beat(input int d, input logic [63:0] a, input logic [63:0] b, input logic last);
        int n;
        n = 0;
        in_a    = a;
        in_b    = b;
        in_last = last;
        vin[d]  = 1'b1;
        @(negedge clk);
        while (!rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept dut%0d: in_ready got 0 want 1 within 50 cycles", d);
        end
        @(posedge clk);
        #1;
        vin[d]  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (ov[d] && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL result_unexpected dut%0d: got %h/%b want no result", d, res[d], ovf[d]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.id != 2'(d) || res[d] !== mon_e.res || ovf[d] !== mon_e.ovf) begin
                        n_bad++;
                        $display("FAIL result dut%0d: got %h ovf %b want dut%0d %h ovf %b",
                                 d, res[d], ovf[d], mon_e.id, mon_e.res, mon_e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        vin       = 4'd0;
        in_a      = 64'd0;
        in_b      = 64'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_valid%0d", d), 32'(ov[d]), 32'd0);
            check($sformatf("reset_ready%0d", d), 32'(rdy[d]), 32'd1);
            check($sformatf("reset_result%0d", d), res[d], 32'd0);
            check($sformatf("reset_ovf%0d", d), 32'(ovf[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Lanes 1..8 times 1 = 36; result appears three edges after the beat is presented.
        expect_result(0, 32'd36, 1'b0);
        beat(0, 64'h0807060504030201, rep(8'd1), 1'b1);
        check("latency_edge1", 32'(ov[0]), 32'd0);
        idle(1);
        check("latency_edge2", 32'(ov[0]), 32'd0);
        idle(1);
        check("latency_edge3", 32'(ov[0]), 32'd1);
        idle(3);

        // Three-beat burst of 255*255 on all lanes: 3*8*65025, delivered exactly once.
        expect_result(0, 32'd1560600, 1'b0);
        beat(0, rep(8'hFF), rep(8'hFF), 1'b0);
        beat(0, rep(8'hFF), rep(8'hFF), 1'b0);
        beat(0, rep(8'hFF), rep(8'hFF), 1'b1);
        idle(6);

        // Signed: -128 * 127 on eight lanes = -130048.
        expect_result(1, 32'hFFFE0400, 1'b0);
        beat(1, rep(8'h80), rep(8'h7F), 1'b1);
        idle(5);

        // 16-bit accumulator, two beats of 8*65025: clamp vs wrap, then sticky clears.
        expect_result(2, 32'h0000FFFF, 1'b1);
        beat(2, rep(8'hFF), rep(8'hFF), 1'b0);
        beat(2, rep(8'hFF), rep(8'hFF), 1'b1);
        expect_result(2, 32'd8, 1'b0);
        beat(2, rep(8'd1), rep(8'd1), 1'b1);
        expect_result(3, 32'h0000E010, 1'b1);
        beat(3, rep(8'hFF), rep(8'hFF), 1'b0);
        beat(3, rep(8'hFF), rep(8'hFF), 1'b1);
        expect_result(3, 32'd8, 1'b0);
        beat(3, rep(8'd1), rep(8'd1), 1'b1);
        idle(6);

        // Single-beat bursts back to back: one result on each consecutive cycle.
        for (int k = 1; k <= 4; k++) begin
            expect_result(0, 32'(8 * k), 1'b0);
            beat(0, rep(8'(k)), rep(8'd1), 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stream_valid%0d", k), 32'(ov[0]), 32'd1);
            idle(1);
        end
        check("stream_drained", 32'(ov[0]), 32'd0);
        idle(3);

        // Backpressure: three results fill the pipe, a fourth beat waits without loss.
        out_ready = 1'b0;
        expect_result(0, 32'd48, 1'b0);
        beat(0, rep(8'd2), rep(8'd3), 1'b1);
        expect_result(0, 32'd8, 1'b0);
        beat(0, rep(8'd1), rep(8'd1), 1'b1);
        expect_result(0, 32'd160, 1'b0);
        beat(0, rep(8'd4), rep(8'd5), 1'b1);
        expect_result(0, 32'd16, 1'b0);
        fork
            beat(0, rep(8'd1), rep(8'd2), 1'b1);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check($sformatf("stall_ready%0d", k), 32'(rdy[0]), 32'd0);
                    check($sformatf("stall_result%0d", k), res[0], 32'd48);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);

        // Reset with a pending result and a half-built burst discards both.
        out_ready = 1'b0;
        beat(0, rep(8'd1), rep(8'd1), 1'b1);
        beat(0, rep(8'hFF), rep(8'hFF), 1'b0);
        beat(0, rep(8'hFF), rep(8'hFF), 1'b0);
        idle(2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_valid", 32'(ov[0]), 32'd0);
        check("midreset_result", res[0], 32'd0);
        check("midreset_ovf", 32'(ovf[0]), 32'd0);
        check("midreset_ready", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        expect_result(0, 32'd8, 1'b0);
        beat(0, rep(8'd1), rep(8'd1), 1'b1);
        idle(8);

        check("results_outstanding", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
